// File: rtl/fe_limb_packer.sv
// fe_limb_packer: packs ten signed 26/25-bit radix limbs into the canonical 256-bit value mod 2^255-19.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/fe_in[0:319] element input, limb i at bits 32*i..32*i+31 MSB-first;
// out_valid/out_ready/out_data[255:0] canonical little-endian result; is_neg (= out_data[0]) only with FE_PACK_SIGN_OUT_EN.
module fe_limb_packer (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [0:319] fe_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [255:0]       out_data
`ifdef FE_PACK_SIGN_OUT_EN
  ,
  output logic               is_neg
`endif
);
  typedef enum logic [1:0] {IDLE, QCALC, REDUCE, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] h [10];
  logic [3:0] k;
  logic signed [63:0] q, carry, hk, qn, t, h9_in;
  logic [5:0] w;
  logic [31:0] tm;
  logic [255:0] pk;
  logic last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE   ? (in_valid ? QCALC : IDLE) :
               state == QCALC  ? (last ? REDUCE : QCALC) :
               state == REDUCE ? (last ? DONE : REDUCE) :
                                 (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  // Shared per-step datapath: q estimation in QCALC, carry propagation in REDUCE.
  always_comb begin
    last  = k == 4'd9;
    w     = k[0] ? 6'd25 : 6'd26;
    hk    = 64'($signed(h[k]));
    h9_in = 64'($signed(fe_in[288 +: 32]));
    qn    = (hk + q) >>> w;
    t     = hk + carry;
    tm    = t[31:0] & ((32'd1 << w) - 32'd1);
    pk    = '0;
    // The last REDUCE step packs limb 9 straight from the step result so out_data loads on that edge.
    for (int i = 0; i < 10; i++)
      pk = pk | ({224'b0, (i == 9 ? tm : h[i])} << (25 * i + (i + 1) / 2));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q        <= '0;
      carry    <= '0;
      k        <= '0;
      out_data <= '0;
      for (int i = 0; i < 10; i++) h[i] <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        for (int i = 0; i < 10; i++) h[i] <= fe_in[32*i +: 32];
        q <= (64'sd19 * h9_in + 64'sd16777216) >>> 25;
        k <= '0;
      end
    end else if (state == QCALC) begin
      q     <= qn;
      k     <= last ? 4'd0 : k + 4'd1;
      carry <= last ? 64'sd19 * qn : carry;
    end else if (state == REDUCE) begin
      h[k]     <= tm;
      carry    <= last ? 64'sd0 : t >>> w;
      k        <= last ? 4'd0 : k + 4'd1;
      out_data <= last ? pk : out_data;
    end
`ifdef FE_PACK_SIGN_OUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) is_neg <= 1'b0;
    else if (state == REDUCE && last) is_neg <= pk[0];
`endif
endmodule

// File: tb/tb_fe_limb_packer.sv
// tb_fe_limb_packer: directed vector bench for fe_limb_packer with a big-integer mod-p reference.
module tb_fe_limb_packer;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic signed [0:319] fe_in = '0;
  logic [255:0] out_data;
`ifdef FE_PACK_SIGN_OUT_EN
  logic is_neg;
`endif
  int pass = 0, total = 0;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
  typedef struct {
    logic [9:0][31:0] h;
    logic [255:0] exp;
  } vec_t;
  vec_t tv [14];
  int rom [8][10];
  always #5 clk = ~clk;
  fe_limb_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .fe_in(fe_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef FE_PACK_SIGN_OUT_EN
    , .is_neg(is_neg)
`endif
  );
  function automatic logic [255:0] ref_mod(input logic [9:0][31:0] h);
    logic signed [299:0] acc, term;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      term = 300'($signed(h[i]));
      acc = acc + (term <<< (25 * i + (i + 1) / 2));
    end
    acc = acc + ($signed({44'b0, P}) <<< 20);
    return 256'($unsigned(acc) % {44'b0, P});
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic drive(input logic [9:0][31:0] h);
    for (int i = 0; i < 10; i++) fe_in[32*i +: 32] = h[i];
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask
  task automatic run_one(input int id);
    int n;
    @(negedge clk);
    drive(tv[id].h);
    in_valid = 1;
    chk($sformatf("v%0d_in_ready", id), in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    wait_done(n);
    chk($sformatf("v%0d_latency", id), n, 20);
    chk($sformatf("v%0d_data", id), out_data, tv[id].exp);
`ifdef FE_PACK_SIGN_OUT_EN
    chk($sformatf("v%0d_is_neg", id), is_neg, tv[id].exp[0]);
`endif
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk($sformatf("v%0d_valid_after_hs", id), out_valid, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: timeout");
    $fatal(1);
  end
  initial begin
    int n;
    logic [255:0] hold;
    rom = '{
      '{12345678, -2345678, 33554431, 0, -1, 1, 7777777, -7777777, 25000000, -25000000},
      '{-33554431, 33554431, -33554431, 33554431, -33554431, 33554431, -33554431, 33554431, -33554431, 33554431},
      '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10},
      '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 33554431},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, -33554431},
      '{31415926, 27182818, 14142135, 17320508, 22360679, 24494897, 26457513, 28284271, 30000000, 31622776},
      '{-19, 0, 0, 0, 0, 0, 0, 0, 0, 0}
    };
    for (int v = 0; v < 14; v++) tv[v].h = '0;
    tv[0].exp = '0;
    tv[1].h[0] = 32'd1;
    tv[1].exp = 256'd1;
    tv[2].h[0] = 32'hFFFF_FFFF;
    tv[2].exp = {1'b0, {250{1'b1}}, 5'b01100};
    for (int i = 0; i < 10; i++) begin
      tv[3].h[i] = i == 0 ? 32'd67108845 : i % 2 ? 32'd33554431 : 32'd67108863;
      tv[4].h[i] = i == 0 ? 32'd67108846 : tv[3].h[i];
      tv[5].h[i] = i % 2 ? 32'd33554431 : 32'd67108863;
    end
    tv[3].exp = '0;
    tv[4].exp = 256'd1;
    tv[5].exp = 256'd18;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 10; i++) tv[6+v].h[i] = rom[v][i];
      tv[6+v].exp = ref_mod(tv[6+v].h);
    end
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
`ifdef FE_PACK_SIGN_OUT_EN
    chk("rst_is_neg", is_neg, 0);
`endif
    @(negedge clk);
    rst_n = 1;
    for (int v = 0; v < 6; v++) run_one(v);
    @(negedge clk);
    drive(tv[6].h);
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    wait_done(n);
    chk("stall_latency", n, 20);
    hold = tv[6].exp;
    for (int c = 0; c < 5; c++) begin
      drive(tv[c].h);
      in_valid = c % 2 == 0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), out_valid, 1);
      chk($sformatf("stall%0d_data", c), out_data, hold);
      chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk("stall_hs_in_ready", in_ready, 1);
    repeat (25) @(negedge clk);
    chk("stall_no_extra", out_valid, 0);
    drive(tv[2].h);
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (13) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    chk("abort_no_output", out_valid, 0);
    run_one(4);
    @(negedge clk);
    drive(tv[6].h);
    in_valid = 1;
    out_ready = 1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_accepted", j), in_ready, 0);
      if (j < 7) drive(tv[7+j].h);
      wait_done(n);
      chk($sformatf("b2b%0d_latency", j), n, 20);
      chk($sformatf("b2b%0d_data", j), out_data, tv[6+j].exp);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_idle", j), in_ready, 1);
    end
    in_valid = 0;
    out_ready = 0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
